// File: rtl/sigma_delta_capture_ctrl.sv
// Capture sequencer for sigma_delta_adc: settle, fixed-length burst into a FIFO, valid/ready stream out.
// Define ADC_PEAK_EN to track min/max of stored samples; otherwise peak_min/peak_max read 0.
module sigma_delta_capture_ctrl #(
  parameter int unsigned ADC_WDTH       = 20,
  parameter int unsigned SETTLE_SAMPLES = 4,
  parameter int unsigned CAPTURE_LEN    = 256,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_WDTH       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                adc_en,
  input  logic [ADC_WDTH-1:0] adc_output,
  input  logic                adc_valid,
  output logic [ADC_WDTH-1:0] cap_data,
  output logic                cap_valid,
  input  logic                cap_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_WDTH-1:0] cap_count,
  output logic [ADC_WDTH-1:0] peak_min,
  output logic [ADC_WDTH-1:0] peak_max
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [CNT_WDTH-1:0] settle_cnt, settle_cnt_nxt;
  logic [CNT_WDTH-1:0] cap_count_nxt;
  logic                overflow_nxt, done_nxt;
  logic                wr_en, rd_en, flush;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [OCC_W-1:0]    occ, occ_nxt;
  logic [ADC_WDTH-1:0] mem [FIFO_DEPTH];
  logic [ADC_WDTH-1:0] head_nxt;

  // Sequencing, capture accounting and FIFO pointer updates
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    cap_count_nxt  = cap_count;
    overflow_nxt   = overflow;
    done_nxt       = 1'b0;
    wr_en          = 1'b0;
    flush          = 1'b0;
    rd_en          = cap_valid && cap_ready && (state != IDLE);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          flush          = 1'b1;
          settle_cnt_nxt = '0;
          cap_count_nxt  = '0;
          overflow_nxt   = 1'b0;
          state_nxt      = (SETTLE_SAMPLES == 0) ? CAPTURE : SETTLE;
        end
      end
      SETTLE: begin
        if (adc_valid) begin
          settle_cnt_nxt = settle_cnt + CNT_WDTH'(1);
          if (settle_cnt == CNT_WDTH'(SETTLE_SAMPLES - 1)) state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          cap_count_nxt = cap_count + CNT_WDTH'(1);
          // Occupancy is judged before this cycle's pop
          if (occ < OCC_W'(FIFO_DEPTH)) wr_en = 1'b1;
          else                          overflow_nxt = 1'b1;
          if (cap_count == CNT_WDTH'(CAPTURE_LEN - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything in a busy state; counters and overflow hold
    if (abort && (state != IDLE)) begin
      state_nxt     = IDLE;
      flush         = 1'b1;
      wr_en         = 1'b0;
      rd_en         = 1'b0;
      done_nxt      = 1'b0;
      cap_count_nxt = cap_count;
      overflow_nxt  = overflow;
    end

    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      occ_nxt    = '0;
    end else begin
      if (wr_en) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      occ_nxt = occ + OCC_W'(wr_en) - OCC_W'(rd_en);
    end

    // Next head: bypass the incoming sample when it becomes the head entry
    head_nxt = '0;
    if (occ_nxt != '0) begin
      if (wr_en && (wr_ptr == rd_ptr_nxt)) head_nxt = adc_output;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      cap_count  <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      adc_en     <= 1'b0;
      busy       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      cap_count  <= cap_count_nxt;
      overflow   <= overflow_nxt;
      done       <= done_nxt;
      adc_en     <= (state_nxt == SETTLE) || (state_nxt == CAPTURE);
      busy       <= (state_nxt != IDLE);
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      occ        <= occ_nxt;
      cap_valid  <= (occ_nxt != '0);
      cap_data   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= adc_output;
  end

`ifdef ADC_PEAK_EN
  // Running min/max of samples written to the FIFO during CAPTURE
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_min <= '1;
      peak_max <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      peak_min <= '1;
      peak_max <= '0;
    end else if (wr_en) begin
      if (adc_output < peak_min) peak_min <= adc_output;
      if (adc_output > peak_max) peak_max <= adc_output;
    end
  end
`else
  assign peak_min = '0;
  assign peak_max = '0;
`endif

endmodule
